single_port_ram: RTL and testbench
==================================

Name: single_port_ram

Overview:
- Synchronous RAM, 64 x 8 by default, single clock, with independent read and write address inputs.
- Write is synchronous, gated by a write enable; read data is registered, with a one-cycle latency.
- Used as a small on-chip buffer or lookup store inside the team's memory IP set; it can be replaced by an inferred block RAM.

Parameters:
- DATA_W, 8, width of each word and of the data/q ports.
- ADDR_W, 6, address width for both read_addr and write_addr.
- DEPTH, 2**ADDR_W (64), number of words; only the full power-of-two range is supported.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  DATA_W  write data.
- read_addr  input  ADDR_W  read address, sampled on the rising clk edge.
- write_addr  input  ADDR_W  write address, sampled on the rising clk edge.
- w  input  1  write enable, active high.
- q  output  DATA_W  registered read data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low immediately forces q to 0, independent of clk.
  - rst_n low also clears all DEPTH words to 0.
  - While rst_n is low, writes are ignored.
  - Release of rst_n is synchronised externally; the first write is accepted on the first rising edge after release.
- Write: on a rising clk edge with rst_n high and w=1, mem[write_addr] <= data. With w=0, memory is unchanged.
- Read:
  - Every rising clk edge with rst_n high does q <= mem[read_addr], regardless of w.
  - Latency is 1 cycle: an address presented before edge N appears on q after edge N.
  - q holds its value between edges.
- Read-during-write, same address (w=1, read_addr==write_addr at the same edge): q returns the OLD content (read-first). The new data is visible on the next read edge.
- Read and write to different addresses on the same edge are fully independent.
- Addresses always lie in range because DEPTH = 2**ADDR_W; there is no wrap or error logic.
- Reset asserted mid-cycle overrides any write on that edge; both q and the memory become 0.
- No X propagation after reset: every location reads 0 until it is written.

Optional Feature:
- Macro: SPRAM_WRITE_FIRST_EN.
- Defined: for a same-address read-during-write, q receives the incoming data (write-first bypass) on that same edge. All other behaviour is unchanged.
- Undefined: read-first behaviour, as specified above.

Decomposition:
- Shared package spram_pkg holds:
  - default constants DATA_W_DEF=8 and ADDR_W_DEF=6;
  - DEPTH derivation;
  - word_t and addr_t typedefs.
- Sub-module spram_rd_mux: a combinational read mux from the memory array plus the optional write-first bypass, isolated so it can be swapped for a vendor macro.
- Top level holds the storage array, the reset clear and the q register.

Test Plan:
- Reset: pulse rst_n low mid-cycle, between edges -> q=0 immediately; then reading addresses 0, 31 and 63 gives q=0.
- Sparse write/readback:
  - Stimulus: with w=1, write data=i at write_addr=i for i=0,10,20,30,40,50,60; then set w=0 and read the same addresses.
  - Required response: one cycle after each read address, q = 8'd0, 8'd10, ..., 8'd60.
- Write enable gating: write 8'hA5 to address 5, then present data=8'h3C at write_addr=5 with w=0 -> reading address 5 returns 8'hA5.
- Read-during-write, same address: address 7 holds 8'h11; write 8'h22 to 7 while read_addr=7 -> q=8'h11 (8'h22 with SPRAM_WRITE_FIRST_EN); the following read gives 8'h22.
- Simultaneous independent access: write 8'hFF to address 63 while reading address 0 (holding 8'h00) -> q=8'h00; the next read of 63 gives 8'hFF.
- Mid-run reset: fill address 10 with 8'h55, assert rst_n for one cycle -> q=0 at once; reading address 10 then returns 8'h00.

Source files
------------

// File: rtl/spram_pkg.sv
// spram_pkg: shared constants and types for single_port_ram
package spram_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 6;
   function automatic int depth_of(input int aw);
      return 2 ** aw;
   endfunction
   localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
   typedef logic [DATA_W_DEF-1:0] word_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
endpackage

// File: rtl/spram_rd_mux.sv
// spram_rd_mux: read mux from the array; SPRAM_WRITE_FIRST_EN adds a same-address write-first bypass
module spram_rd_mux #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic [DATA_W-1:0] mem [DEPTH],
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] data,
   input  logic              w,
   output logic [DATA_W-1:0] rd_data
);
`ifdef SPRAM_WRITE_FIRST_EN
   assign rd_data = (w && read_addr == write_addr) ? data : mem[read_addr];
`else
   logic unused_wr;
   assign unused_wr = ^{w, write_addr, data};
   assign rd_data = mem[read_addr];
`endif
endmodule

// File: rtl/single_port_ram.sv
// single_port_ram: 64x8 synchronous RAM, registered read, read-first unless SPRAM_WRITE_FIRST_EN
module single_port_ram
   import spram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = depth_of(ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic              w,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;

   spram_rd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_mux (
      .mem(mem),
      .read_addr(read_addr),
      .write_addr(write_addr),
      .data(data),
      .w(w),
      .rd_data(rd_data)
   );

   // reset clears the whole array so no location ever reads X
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         q <= rd_data;
         if (w) mem[write_addr] <= data;
      end
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: directed and random checks of single_port_ram against an array model
module tb_single_port_ram;
   import spram_pkg::*;
   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   word_t data = '0;
   addr_t read_addr = '0;
   addr_t write_addr = '0;
   logic  w = 1'b0;
   word_t q;
   word_t model [DEPTH_DEF];
   int    checks = 0;
   int    failures = 0;

   single_port_ram dut (
      .clk(clk),
      .rst_n(rst_n),
      .data(data),
      .read_addr(read_addr),
      .write_addr(write_addr),
      .w(w),
      .q(q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t exp);
      checks++;
      assert (q === exp) else begin
         failures++;
         $error("FAIL %s q=%02h expected=%02h", tag, q, exp);
      end
   endtask

   task automatic step(input string tag, input logic wr, input int wa, input int d, input int ra);
      word_t exp;
      @(negedge clk);
      w = wr;
      write_addr = addr_t'(wa);
      data = word_t'(d);
      read_addr = addr_t'(ra);
      @(posedge clk);
      exp = model[ra];
`ifdef SPRAM_WRITE_FIRST_EN
      if (wr && wa == ra) exp = word_t'(d);
`endif
      if (wr) model[wa] = word_t'(d);
      #1 check(tag, exp);
   endtask

   // reset asserted between edges; a write attempted while low must be ignored
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check(tag, 8'h00);
      for (int i = 0; i < DEPTH_DEF; i++) model[i] = '0;
      w = 1'b1;
      write_addr = 6'd10;
      data = 8'hEE;
      read_addr = 6'd10;
      @(posedge clk);
      #1 check({tag, "_hold"}, 8'h00);
      @(negedge clk);
      w = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH_DEF; i++) model[i] = '0;
      @(posedge clk);
      pulse_reset("reset");
      step("rst_rd0", 1'b0, 0, 0, 0);
      step("rst_rd31", 1'b0, 0, 0, 31);
      step("rst_rd63", 1'b0, 0, 0, 63);
      for (int i = 0; i <= 60; i += 10) step("sparse_wr", 1'b1, i, i, 63);
      for (int i = 0; i <= 60; i += 10) begin
         step("sparse_rd", 1'b0, 0, 0, i);
         check("sparse_const", word_t'(i));
      end
      step("wen_wr", 1'b1, 5, 8'hA5, 0);
      step("wen_off", 1'b0, 5, 8'h3C, 0);
      step("wen_rd", 1'b0, 0, 0, 5);
      check("wen_const", 8'hA5);
      step("rdw_pre", 1'b1, 7, 8'h11, 0);
      step("rdw_same", 1'b1, 7, 8'h22, 7);
`ifdef SPRAM_WRITE_FIRST_EN
      check("rdw_const", 8'h22);
`else
      check("rdw_const", 8'h11);
`endif
      step("rdw_next", 1'b0, 0, 0, 7);
      check("rdw_next_const", 8'h22);
      step("indep", 1'b1, 63, 8'hFF, 0);
      check("indep_const", 8'h00);
      step("indep_rd", 1'b0, 0, 0, 63);
      check("indep_rd_const", 8'hFF);
      step("mid_fill", 1'b1, 10, 8'h55, 10);
      step("mid_chk", 1'b0, 0, 0, 10);
      check("mid_chk_const", 8'h55);
      pulse_reset("mid_reset");
      step("mid_rd", 1'b0, 0, 0, 10);
      check("mid_rd_const", 8'h00);
      // narrow address range forces frequent same-address collisions
      for (int n = 0; n < 400; n++) begin
         int mask;
         mask = (n < 200) ? 7 : 63;
         step("rand", 1'($urandom_range(0, 1)), int'($urandom) & mask,
              int'($urandom_range(0, 255)), int'($urandom) & mask);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
